// File: rtl/mario_pkg.sv
// Shared game constants and the tile-write arbiter state type.
package mario_pkg;

    localparam logic [7:0] BDR = 8'd0;
    localparam logic [7:0] SKY = 8'd1;
    localparam logic [7:0] BLK = 8'd2;
    localparam logic [7:0] GND = 8'd3;
    localparam logic [7:0] TKN = 8'd4;

    localparam int BLOCK_WIDTH   = 40;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } arb_state_t;

endpackage

// File: rtl/tile_write_arbiter_if.sv
// Requester-side and tile-map-side signals of the tile write arbiter.
interface tile_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ROWS    = 12,
    parameter int COLS    = 17,
    parameter int TILE_W  = 8,
    parameter int SCORE_W = 10
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0][ROW_W-1:0]  req_row;
    logic [NUM_REQ-1:0][COL_W-1:0]  req_col;
    logic [NUM_REQ-1:0][TILE_W-1:0] req_tile;
    logic [NUM_REQ-1:0]             req_coin;
    logic                           vblank;
    logic [NUM_REQ-1:0]             ack;
    logic                           wr_en;
    logic [ROW_W-1:0]               wr_row;
    logic [COL_W-1:0]               wr_col;
    logic [TILE_W-1:0]              wr_tile;
    logic                           busy;
    logic [SCORE_W-1:0]             score;

    modport master (
        output req, req_row, req_col, req_tile, req_coin, vblank,
        input  ack, wr_en, wr_row, wr_col, wr_tile, busy, score
    );

    modport slave (
        input  req, req_row, req_col, req_tile, req_coin, vblank,
        output ack, wr_en, wr_row, wr_col, wr_tile, busy, score
    );

endinterface

// File: rtl/tile_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

    logic [N-1:0][IDX_W:0]   sum;
    logic [N-1:0][IDX_W-1:0] cand;
    logic [N-1:0]            hit;

    // cand[gi] is the requester gi places after the pointer
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign sum[gi]  = {1'b0, ptr} + (IDX_W+1)'(gi);
        assign cand[gi] = (sum[gi] >= N_W) ? IDX_W'(sum[gi] - N_W) : IDX_W'(sum[gi]);
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) idx = cand[i];
        end
    end

endmodule

// File: rtl/tile_write_arbiter.sv
// Round-robin arbiter serializing tile-map writes with a saturating coin score.
// Define TILE_ARB_VBLANK_GATE_EN to allow new grants only while vblank is high.
module tile_write_arbiter
    import mario_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ROWS    = 12,
    parameter int COLS    = 17,
    parameter int TILE_W  = 8,
    parameter int SCORE_W = 10
) (
    input  logic vga_clock,
    input  logic reset,
    tile_write_arbiter_if.slave bus
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state_reg, state_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [IDX_W-1:0]   grant_reg, grant_next;
    logic               coin_reg, coin_next;
    logic [NUM_REQ-1:0] ack_reg, ack_next;
    logic               wr_en_reg, wr_en_next;
    logic [ROW_W-1:0]   wr_row_reg, wr_row_next;
    logic [COL_W-1:0]   wr_col_reg, wr_col_next;
    logic [TILE_W-1:0]  wr_tile_reg, wr_tile_next;
    logic               busy_reg, busy_next;
    logic [SCORE_W-1:0] score_reg, score_next;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               window;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [ROW_W-1:0]   pick_row;
    logic [COL_W-1:0]   pick_col;

`ifdef TILE_ARB_VBLANK_GATE_EN
    assign window = bus.vblank;
`else
    logic unused_vblank;
    assign unused_vblank = bus.vblank;
    assign window        = 1'b1;
`endif

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_reg),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign pick_row = bus.req_row[pick_idx];
    assign pick_col = bus.req_col[pick_idx];

    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            grant_reg   <= '0;
            coin_reg    <= 1'b0;
            ack_reg     <= '0;
            wr_en_reg   <= 1'b0;
            wr_row_reg  <= '0;
            wr_col_reg  <= '0;
            wr_tile_reg <= '0;
            busy_reg    <= 1'b0;
            score_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            grant_reg   <= grant_next;
            coin_reg    <= coin_next;
            ack_reg     <= ack_next;
            wr_en_reg   <= wr_en_next;
            wr_row_reg  <= wr_row_next;
            wr_col_reg  <= wr_col_next;
            wr_tile_reg <= wr_tile_next;
            busy_reg    <= busy_next;
            score_reg   <= score_next;
        end
    end

    // Outputs are registered, so the strobes computed in IDLE are visible during WRITE
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        grant_next   = grant_reg;
        coin_next    = coin_reg;
        ack_next     = '0;
        wr_en_next   = 1'b0;
        wr_row_next  = wr_row_reg;
        wr_col_next  = wr_col_reg;
        wr_tile_next = wr_tile_reg;
        busy_next    = busy_reg;
        score_next   = score_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid && window) begin
                    state_next   = WRITE;
                    grant_next   = pick_idx;
                    coin_next    = bus.req_coin[pick_idx];
                    wr_row_next  = pick_row;
                    wr_col_next  = pick_col;
                    wr_tile_next = bus.req_tile[pick_idx];
                    ack_next     = pick_onehot;
                    wr_en_next   = (int'(pick_row) < ROWS) && (int'(pick_col) < COLS);
                    busy_next    = 1'b1;
                end
            end
            WRITE: begin
                state_next = DONE;
                busy_next  = 1'b1;
                ptr_next   = (int'(grant_reg) == NUM_REQ - 1) ? '0 : grant_reg + 1'b1;
                if (wr_en_reg && coin_reg && (score_reg != '1))
                    score_next = score_reg + 1'b1;
            end
            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign bus.ack     = ack_reg;
    assign bus.wr_en   = wr_en_reg;
    assign bus.wr_row  = wr_row_reg;
    assign bus.wr_col  = wr_col_reg;
    assign bus.wr_tile = wr_tile_reg;
    assign bus.busy    = busy_reg;
    assign bus.score   = score_reg;

endmodule

// File: tb/tb_tile_write_arbiter.sv
// Directed self-checking bench for tile_write_arbiter (main DUT plus a SCORE_W=2 instance).
module tb_tile_write_arbiter;
    import mario_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    tile_write_arbiter_if #(.NUM_REQ(4), .ROWS(12), .COLS(17), .TILE_W(8), .SCORE_W(10)) bus ();
    tile_write_arbiter_if #(.NUM_REQ(4), .ROWS(12), .COLS(17), .TILE_W(8), .SCORE_W(2))  bus_s ();

    tile_write_arbiter #(.NUM_REQ(4), .ROWS(12), .COLS(17), .TILE_W(8), .SCORE_W(10)) dut (
        .vga_clock (clk),
        .reset     (rst_n),
        .bus       (bus)
    );

    tile_write_arbiter #(.NUM_REQ(4), .ROWS(12), .COLS(17), .TILE_W(8), .SCORE_W(2)) dut_s (
        .vga_clock (clk),
        .reset     (rst_n),
        .bus       (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req      = '0;
        bus.req_row  = '0;
        bus.req_col  = '0;
        bus.req_tile = '0;
        bus.req_coin = '0;
        bus.vblank   = 1'b0;
        bus_s.req      = '0;
        bus_s.req_row  = '0;
        bus_s.req_col  = '0;
        bus_s.req_tile = '0;
        bus_s.req_coin = '0;
        bus_s.vblank   = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.ack, bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_tile, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b wr_en=%b wr=(%0d,%0d,%0d) busy=%b, want all 0",
                     bus.ack, bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_tile, bus.busy);
        end
        checks++;
        if (bus.score !== 10'd0 || bus_s.score !== 2'd0) begin
            errors++;
            $display("FAIL reset_score: got %0d/%0d, want 0/0", bus.score, bus_s.score);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b ack=%b, want 0 0000", bus.busy, bus.ack);
        end
        $display("txn reset released");
    endtask

    task automatic test_single();
        bus.req_row[0]  = 4'd6;
        bus.req_col[0]  = 5'd6;
        bus.req_tile[0] = SKY;
        bus.req_coin[0] = 1'b1;
        bus.req[0]      = 1'b1;
        tick();
        checks++;
        if (bus.ack !== 4'b0001 || bus.wr_en !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_ack: got ack=%b wr_en=%b busy=%b, want 0001 1 1", bus.ack, bus.wr_en, bus.busy);
        end
        checks++;
        if (bus.wr_row !== 4'd6 || bus.wr_col !== 5'd6 || bus.wr_tile !== 8'd1) begin
            errors++;
            $display("FAIL single_fields: got (%0d,%0d,%0d), want (6,6,1)", bus.wr_row, bus.wr_col, bus.wr_tile);
        end
        bus.req[0] = 1'b0;
        tick();
        checks++;
        if (bus.score !== 10'd1 || bus.ack !== 4'b0000 || bus.wr_en !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_done: got score=%0d ack=%b wr_en=%b busy=%b, want 1 0000 0 1",
                     bus.score, bus.ack, bus.wr_en, bus.busy);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.score !== 10'd1) begin
            errors++;
            $display("FAIL single_idle: got busy=%b score=%0d, want 0 1", bus.busy, bus.score);
        end
        $display("txn single req0 -> (6,6,SKY) score=%0d", bus.score);
    endtask

    task automatic test_out_of_range();
        logic [3:0] rows [2];
        logic [4:0] cols [2];
        rows[0] = 4'd12; cols[0] = 5'd3;
        rows[1] = 4'd3;  cols[1] = 5'd17;
        for (int t = 0; t < 2; t++) begin
            bus.req_row[2]  = rows[t];
            bus.req_col[2]  = cols[t];
            bus.req_tile[2] = TKN;
            bus.req_coin[2] = 1'b1;
            bus.req[2]      = 1'b1;
            tick();
            checks++;
            if (bus.ack !== 4'b0100 || bus.wr_en !== 1'b0) begin
                errors++;
                $display("FAIL oor_ack_%0d: got ack=%b wr_en=%b, want 0100 0", t, bus.ack, bus.wr_en);
            end
            bus.req[2] = 1'b0;
            tick();
            tick();
            checks++;
            if (bus.score !== 10'd1) begin
                errors++;
                $display("FAIL oor_score_%0d: got %0d, want 1", t, bus.score);
            end
            $display("txn out-of-range (%0d,%0d) acked, score=%0d", rows[t], cols[t], bus.score);
        end
    endtask

    task automatic test_vblank();
        int early_acks;
        early_acks = 0;
        bus.req_row[1]  = 4'd2;
        bus.req_col[1]  = 5'd9;
        bus.req_tile[1] = BLK;
        bus.req_coin[1] = 1'b1;
        bus.vblank      = 1'b0;
        bus.req[1]      = 1'b1;
`ifdef TILE_ARB_VBLANK_GATE_EN
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.ack !== 4'b0000) early_acks++;
        end
        checks++;
        if (early_acks !== 0) begin
            errors++;
            $display("FAIL vblank_hold: got %0d acks in active video, want 0", early_acks);
        end
        bus.vblank = 1'b1;
`endif
        tick();
        checks++;
        if (bus.ack !== 4'b0010 || bus.wr_en !== 1'b1 || bus.wr_tile !== 8'd2 || early_acks !== 0) begin
            errors++;
            $display("FAIL vblank_grant: got ack=%b wr_en=%b tile=%0d, want 0010 1 2", bus.ack, bus.wr_en, bus.wr_tile);
        end
        bus.req[1] = 1'b0;
        bus.vblank = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.score !== 10'd2) begin
            errors++;
            $display("FAIL vblank_score: got %0d, want 2", bus.score);
        end
        $display("txn vblank req1 -> (2,9,BLK) score=%0d", bus.score);
    endtask

    task automatic test_reset_mid();
        bus.req_row[3]  = 4'd1;
        bus.req_col[3]  = 5'd1;
        bus.req_tile[3] = GND;
        bus.req_coin[3] = 1'b1;
        bus.req[3]      = 1'b1;
        tick();
        checks++;
        if (bus.ack !== 4'b1000 || bus.wr_en !== 1'b1) begin
            errors++;
            $display("FAIL midrst_write: got ack=%b wr_en=%b, want 1000 1", bus.ack, bus.wr_en);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ack, bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_tile, bus.busy} !== '0 || bus.score !== 10'd0) begin
            errors++;
            $display("FAIL midrst_async: got ack=%b wr_en=%b wr=(%0d,%0d,%0d) busy=%b score=%0d, want all 0",
                     bus.ack, bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_tile, bus.busy, bus.score);
        end
        bus.req = '0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.score !== 10'd0 || bus.ack !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_idle: got busy=%b score=%0d ack=%b, want 0 0 0000", bus.busy, bus.score, bus.ack);
        end
        bus.req_row[0] = 4'd4;
        bus.req_col[0] = 5'd4;
        bus.req_coin   = '0;
        bus.req        = 4'b1001;
        tick();
        checks++;
        if (bus.ack !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_ptr: got ack=%b, want 0001", bus.ack);
        end
        bus.req = '0;
        tick();
        tick();
        $display("txn reset mid-write, regrant ack=0001");
    endtask

    task automatic test_round_robin();
        int n_acks;
        int ack_cyc [8];
        logic [3:0] ack_val [8];
        logic [3:0] ack_row [8];
        logic [3:0] exp_ack [5];
        exp_ack[0] = 4'b0001; exp_ack[1] = 4'b0010; exp_ack[2] = 4'b0100;
        exp_ack[3] = 4'b1000; exp_ack[4] = 4'b0001;
        n_acks = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_row[i]  = 4'(i + 1);
            bus.req_col[i]  = 5'(i + 2);
            bus.req_tile[i] = 8'(i);
        end
        bus.req_coin = '0;
        bus.req      = 4'b1111;
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (bus.ack !== 4'b0000 && n_acks < 8) begin
                ack_cyc[n_acks] = c;
                ack_val[n_acks] = bus.ack;
                ack_row[n_acks] = bus.wr_row;
                n_acks++;
            end
        end
        bus.req = '0;
        checks++;
        if (n_acks !== 5) begin
            errors++;
            $display("FAIL rr_count: got %0d acks, want 5", n_acks);
        end
        for (int k = 0; k < 5 && k < n_acks; k++) begin
            checks++;
            if (ack_val[k] !== exp_ack[k] || ack_cyc[k] !== 1 + 3 * k) begin
                errors++;
                $display("FAIL rr_ack_%0d: got ack=%b at cycle %0d, want %b at cycle %0d",
                         k, ack_val[k], ack_cyc[k], exp_ack[k], 1 + 3 * k);
            end
            checks++;
            if (ack_row[k] !== 4'((k % 4) + 1)) begin
                errors++;
                $display("FAIL rr_row_%0d: got %0d, want %0d", k, ack_row[k], (k % 4) + 1);
            end
            $display("txn rr ack=%b cycle=%0d row=%0d", ack_val[k], ack_cyc[k], ack_row[k]);
        end
        tick();
        tick();
        checks++;
        if (bus.score !== 10'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_end: got score=%0d busy=%b, want 0 0", bus.score, bus.busy);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_score [5];
        exp_score[0] = 2'd1; exp_score[1] = 2'd2; exp_score[2] = 2'd3;
        exp_score[3] = 2'd3; exp_score[4] = 2'd3;
        bus_s.vblank      = 1'b1;
        bus_s.req_row[0]  = 4'd5;
        bus_s.req_col[0]  = 5'd16;
        bus_s.req_tile[0] = TKN;
        bus_s.req_coin[0] = 1'b1;
        for (int t = 0; t < 5; t++) begin
            bus_s.req[0] = 1'b1;
            tick();
            checks++;
            if (bus_s.ack !== 4'b0001 || bus_s.wr_en !== 1'b1) begin
                errors++;
                $display("FAIL sat_ack_%0d: got ack=%b wr_en=%b, want 0001 1", t, bus_s.ack, bus_s.wr_en);
            end
            bus_s.req[0] = 1'b0;
            tick();
            checks++;
            if (bus_s.score !== exp_score[t]) begin
                errors++;
                $display("FAIL sat_score_%0d: got %0d, want %0d", t, bus_s.score, exp_score[t]);
            end
            $display("txn coin write %0d score=%0d", t, bus_s.score);
            tick();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_out_of_range();
        test_vblank();
        test_reset_mid();
        test_round_robin();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tile_write_arbiter.md
# tile_write_arbiter

Round-robin arbiter that shares the single write port of the background tile map between several tile-update requesters, such as coin-touch detectors and block-hit logic. It replaces ad-hoc fixed-priority writes into the map with a serialized req/ack handshake. It can restrict map writes to vertical blanking and keeps a saturating collected-coin score. It sits between the requesters and the tile-map storage in the top level, in the `vga_clock` domain.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8)
- `ROWS`, 12: tile-map rows
- `COLS`, 17: tile-map columns
- `TILE_W`, 8: tile code width
- `SCORE_W`, 10: score counter width
- `vga_clock`  in  1: sole clock
- `reset`  in  1: asynchronous, active-low reset
- `req`  in  NUM_REQ: per-requester level request
- `req_row`  in  NUM_REQ x $clog2(ROWS): target row
- `req_col`  in  NUM_REQ x $clog2(COLS): target column
- `req_tile`  in  NUM_REQ x TILE_W: new tile code
- `req_coin`  in  NUM_REQ: request is a coin collection (scores)
- `vblank`  in  1: high during vertical blanking
- `ack`  out  NUM_REQ: one-cycle completion pulse, one-hot
- `wr_en`  out  1: map write strobe
- `wr_row`, `wr_col`, `wr_tile`  out: write address and data
- `busy`  out  1: FSM not in IDLE
- `score`  out  SCORE_W: coins collected

## Operation
- Registered outputs. Reset values:
  - `ack`=0, `wr_en`=0
  - `wr_row`/`wr_col`/`wr_tile`=0
  - `busy`=0, `score`=0
  - rr pointer=0, state IDLE
- FSM states: IDLE, WRITE, DONE.
  - IDLE: if any `req` bit is set and the write window is open, grant the first requester at or after the rr pointer, wrapping modulo NUM_REQ. Latch its row, col, tile and coin fields, then go to WRITE.
  - WRITE: pulse `ack[grant]`. If the latched row < ROWS and col < COLS, also pulse `wr_en` with the latched fields. Set rr pointer to grant+1, wrapping from NUM_REQ-1 to 0. Go to DONE.
  - DONE: one idle cycle so requesters can drop `req`. Return to IDLE.
- Handshake: the requester holds `req` and its fields stable until it sees `ack`. It deasserts `req` in the cycle after `ack`. A `req` still high when the FSM re-enters IDLE is treated as a new request.
- Out-of-range address: the request is acked, no `wr_en` is issued, and the score is unchanged.
- Score: +1 on each WRITE with `wr_en` and latched coin=1. Saturates at 2^SCORE_W-1; no wrap.
- Simultaneous requests: exactly one grant per transaction. Round-robin guarantees each held request is served within NUM_REQ transactions.
- Window closing mid-transaction: once granted, WRITE and DONE complete regardless of `vblank`.
- Reset mid-transaction: the pending write is abandoned with no `ack`. Requesters re-request after reset.

## Timing
- Cycle N, IDLE: `req` sampled and grant chosen.
- Cycle N+1: `wr_en` and `ack` high for exactly one cycle.
- Cycle N+2: DONE.
- Cycle N+3: next IDLE sample.
- Latency from `req` to `ack` is 1 cycle when the window is open. Peak throughput is one write per 3 cycles.
- `score` updates on the clock edge ending the WRITE cycle.
- `busy` is high in WRITE and DONE.

## Configuration
- `TILE_ARB_VBLANK_GATE_EN` defined: the write window is open only while `vblank`=1. Requests that arrive during active video wait in IDLE.
- Not defined: the window is always open and `vblank` is ignored.

## Structure
- Shared package `mario_pkg` holds:
  - tile codes BDR=0, SKY=1, BLK=2, GND=3, TKN=4
  - BLOCK_WIDTH=40, SCREEN_WIDTH=640, SCREEN_HEIGHT=480
  - `arb_state_t` enum (IDLE, WRITE, DONE)
- Sub-module `rr_pick`: combinational round-robin selector.
  - Inputs: request vector and pointer.
  - Outputs: grant index and valid.

## Test plan
- Single request, macro off: `req[0]`=1, row 6, col 6, tile SKY, coin=1.
  - `wr_en` and `ack[0]` high in cycle N+1 with wr=(6,6,1).
  - `score` reads 1 from cycle N+2.
- All four `req` held continuously from reset with pointer 0: `ack` order 0,1,2,3,0, with `ack` pulses 3 cycles apart.
- Out-of-range request: row 12, col 3. `ack` pulses, `wr_en` stays 0, `score` unchanged.
- Macro defined, `req[1]` raised with `vblank`=0 for 20 cycles: no `ack`. Raise `vblank`: `ack[1]` and `wr_en` follow 1 cycle later.
- Saturation: SCORE_W=2, five coin writes. `score` sequence is 1,2,3,3,3.
- Reset asserted in WRITE: all outputs 0 asynchronously. After release the FSM is in IDLE, `score`=0 and pointer=0.
